// File: rtl/cpu_pkg.sv
// Shared types for the accumulator core front end: decoded-op classes, operand
// flags, opcode constants and the byte-assembled instruction decoder.
package cpu_pkg;

    typedef enum logic [4:0] {
        OP_NOP     = 5'd0,
        OP_HALT    = 5'd1,
        OP_PUSH    = 5'd2,
        OP_POP     = 5'd3,
        OP_RET     = 5'd4,
        OP_NOT     = 5'd5,
        OP_OUTLO   = 5'd6,
        OP_SETDP   = 5'd7,
        OP_LOADI   = 5'd8,
        OP_LOAD    = 5'd9,
        OP_ADD     = 5'd10,
        OP_STORE   = 5'd11,
        OP_SUB     = 5'd12,
        OP_AND     = 5'd13,
        OP_OR      = 5'd14,
        OP_XOR     = 5'd15,
        OP_BR      = 5'd16,
        OP_CALL    = 5'd17,
        OP_IF      = 5'd18,
        OP_ILLEGAL = 5'd19
    } op_t;

    typedef enum logic [1:0] {SRC_NONE, SRC_IMM, SRC_RAM, SRC_IND} src_t;
    typedef enum logic [1:0] {REL_NONE, REL_DATA, REL_STACK} rel_t;
    typedef enum logic [2:0] {COND_NONE, COND_Z, COND_NZ, COND_ELSE, COND_NELSE} cond_t;
    typedef enum logic [1:0] {S_OP, S_ARG, S_DATA} asm_state_t;

    localparam logic [7:0] OPC_NOP   = 8'h00;
    localparam logic [7:0] OPC_HALT  = 8'h01;
    localparam logic [7:0] OPC_PUSH  = 8'h04;
    localparam logic [7:0] OPC_POP   = 8'h05;
    localparam logic [7:0] OPC_RET   = 8'h06;
    localparam logic [7:0] OPC_NOT   = 8'h07;
    localparam logic [7:0] OPC_OUTLO = 8'h08;
    localparam logic [7:0] OPC_SETDP = 8'h0A;
    localparam logic [7:0] OPC_LOADI = 8'h44;

    localparam logic [4:0] CLS_LOAD  = 5'b10000;
    localparam logic [4:0] CLS_ADD   = 5'b10001;
    localparam logic [4:0] CLS_STORE = 5'b10010;
    localparam logic [4:0] CLS_SUB   = 5'b10011;
    localparam logic [4:0] CLS_AND   = 5'b10100;
    localparam logic [4:0] CLS_OR    = 5'b10101;
    localparam logic [4:0] CLS_XOR   = 5'b10110;
    localparam logic [4:0] CLS_BR    = 5'b11000;
    localparam logic [4:0] CLS_CALL  = 5'b11010;
    localparam logic [4:0] CLS_IF    = 5'b11110;

    // rhs is kept at 16 bits in the queue; the top extends it to WORD_W at the head.
    typedef struct packed {
        op_t         op;
        logic [15:0] rhs;
        logic [1:0]  len;
        src_t        src;
        rel_t        rel;
        cond_t       cond;
        logic        is_loadi;
    } dec_entry_t;

    function automatic logic needs_data(input logic [7:0] b0);
        return b0[7] & ~b0[6] & b0[1];
    endfunction

    function automatic dec_entry_t decode(input logic [15:0] inst, input logic [7:0] data);
        dec_entry_t e;
        logic       one_arg;
        e       = '0;
        one_arg = 1'b0;
        e.len   = !inst[15] ? 2'd1 : (needs_data(inst[15:8]) ? 2'd3 : 2'd2);
        case (inst[10:8])
            3'b000:  e.rhs = {8'h00, inst[7:0]};
            3'b001:  e.rhs = {inst[7:0], 8'h00};
            3'b010:  e.rhs = {8'h00, data};
            3'b011:  e.rhs = {data, 8'h00};
            default: e.rhs = {8'h00, inst[7:0]};
        endcase
        if (!inst[15]) begin
            case (inst[15:8])
                OPC_NOP:   e.op = OP_NOP;
                OPC_HALT:  e.op = OP_HALT;
                OPC_PUSH:  e.op = OP_PUSH;
                OPC_POP:   e.op = OP_POP;
                OPC_RET:   e.op = OP_RET;
                OPC_NOT:   e.op = OP_NOT;
                OPC_OUTLO: e.op = OP_OUTLO;
                OPC_SETDP: e.op = OP_SETDP;
                OPC_LOADI: begin
                    e.op       = OP_LOADI;
                    e.src      = SRC_RAM;
                    e.rel      = REL_DATA;
                    e.is_loadi = 1'b1;
                end
                default:   e.op = OP_ILLEGAL;
            endcase
        end else begin
            case (inst[15:11])
                CLS_LOAD:  begin e.op = OP_LOAD;  one_arg = 1'b1; end
                CLS_ADD:   begin e.op = OP_ADD;   one_arg = 1'b1; end
                CLS_STORE: begin e.op = OP_STORE; one_arg = 1'b1; end
                CLS_SUB:   begin e.op = OP_SUB;   one_arg = 1'b1; end
                CLS_AND:   begin e.op = OP_AND;   one_arg = 1'b1; end
                CLS_OR:    begin e.op = OP_OR;    one_arg = 1'b1; end
                CLS_XOR:   begin e.op = OP_XOR;   one_arg = 1'b1; end
                CLS_BR:    begin e.op = OP_BR;   e.rhs = {{5{inst[10]}}, inst[10:0]}; end
                CLS_CALL:  begin e.op = OP_CALL; e.rhs = {{5{inst[10]}}, inst[10:0]}; end
                CLS_IF: begin
                    if (inst[10:2] == 9'd0) begin
                        e.op = OP_IF;
                        case (inst[1:0])
                            2'b00:   e.cond = COND_Z;
                            2'b01:   e.cond = COND_NZ;
                            2'b10:   e.cond = COND_ELSE;
                            default: e.cond = COND_NELSE;
                        endcase
                    end else begin
                        e.op = OP_ILLEGAL;
                    end
                end
                default:   e.op = OP_ILLEGAL;
            endcase
        end
        if (one_arg) begin
            if (!inst[10]) begin
                e.src = SRC_IMM;
            end else begin
                e.src = inst[8] ? SRC_IND : SRC_RAM;
                e.rel = inst[9] ? REL_STACK : REL_DATA;
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, first-word fall-through read and
// a synchronous flush that overrides push and pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/fetch_decode_queue.sv
// Assembles 1-3 byte instructions from the fetch stream, decodes them and
// queues the decoded entries for the execute stage.
module fetch_decode_queue
    import cpu_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [WORD_W-1:0] accum,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [4:0]        dec_op,
    output logic [WORD_W-1:0] dec_rhs,
    output logic [1:0]        dec_len,
    output logic [1:0]        dec_src,
    output logic [1:0]        dec_rel,
    output logic [2:0]        dec_cond
);
    localparam int ENTRY_W = $bits(dec_entry_t);

    asm_state_t         r_state;
    asm_state_t         w_state_next;
    logic [7:0]         r_b0;
    logic [7:0]         r_b1;
    logic [15:0]        w_inst;
    logic [7:0]         w_data;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    dec_entry_t         w_dec;
    dec_entry_t         w_head;
    logic [ENTRY_W-1:0] w_head_bits;

    assign byte_ready = ~rst & ~w_full & ~flush;
    assign w_accept   = byte_valid & byte_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_inst       = {byte_data, 8'h00};
        w_data       = 8'h00;
        w_push       = 1'b0;
        case (r_state)
            S_OP: begin
                if (w_accept) begin
                    if (byte_data[7]) w_state_next = S_ARG;
                    else              w_push       = 1'b1;
                end
            end
            S_ARG: begin
                w_inst = {r_b0, byte_data};
                if (w_accept) begin
                    if (needs_data(r_b0)) begin
                        w_state_next = S_DATA;
                    end else begin
                        w_push       = 1'b1;
                        w_state_next = S_OP;
                    end
                end
            end
            S_DATA: begin
                w_inst = {r_b0, r_b1};
                w_data = byte_data;
                if (w_accept) begin
                    w_push       = 1'b1;
                    w_state_next = S_OP;
                end
            end
            default: w_state_next = S_OP;
        endcase
        if (flush) w_state_next = S_OP;
    end

    assign w_dec = decode(w_inst, w_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OP;
            r_b0    <= 8'h00;
            r_b1    <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (w_accept && r_state == S_OP)  r_b0 <= byte_data;
            if (w_accept && r_state == S_ARG) r_b1 <= byte_data;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (w_dec),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_head    = dec_entry_t'(w_head_bits);
    assign dec_valid = ~w_empty;
    assign w_pop     = dec_valid & dec_ready;

    // LOADI reads the live accumulator at the head rather than a captured copy.
    always_comb begin
        dec_op   = 5'd0;
        dec_rhs  = '0;
        dec_len  = 2'd0;
        dec_src  = 2'd0;
        dec_rel  = 2'd0;
        dec_cond = 3'd0;
        if (dec_valid) begin
            dec_op   = w_head.op;
            dec_len  = w_head.len;
            dec_src  = w_head.src;
            dec_rel  = w_head.rel;
            dec_cond = w_head.cond;
            if (w_head.is_loadi)
                dec_rhs = accum;
            else if (w_head.op == OP_BR || w_head.op == OP_CALL)
                dec_rhs = WORD_W'($signed(w_head.rhs));
            else
                dec_rhs = WORD_W'(w_head.rhs);
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios plus a random
// byte stream checked against a byte-level reference model.
module tb_fetch_decode_queue;
    import cpu_pkg::*;

    localparam int WORD_W = 16;
    localparam int QDEPTH = 2;
    localparam int OBS_W  = WORD_W + 15;
    localparam logic [7:0] ONE_BYTE [9] = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h06,
                                            8'h07, 8'h08, 8'h0A, 8'h44};

    typedef struct {
        logic [4:0]  op;
        logic [15:0] rhs;
        logic [1:0]  len;
        logic [1:0]  src;
        logic [1:0]  rel;
        logic [2:0]  cond;
        bit          loadi;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic [WORD_W-1:0] accum = '0;
    logic              dec_valid;
    logic              dec_ready = 1'b0;
    logic [4:0]        dec_op;
    logic [WORD_W-1:0] dec_rhs;
    logic [1:0]        dec_len;
    logic [1:0]        dec_src;
    logic [1:0]        dec_rel;
    logic [2:0]        dec_cond;

    int n_cmp = 0;
    int n_err = 0;

    wire [OBS_W-1:0] w_obs = {dec_valid, dec_op, dec_rhs, dec_len, dec_src, dec_rel, dec_cond};

    fetch_decode_queue #(.WORD_W(WORD_W), .QDEPTH(QDEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .accum      (accum),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_op     (dec_op),
        .dec_rhs    (dec_rhs),
        .dec_len    (dec_len),
        .dec_src    (dec_src),
        .dec_rel    (dec_rel),
        .dec_cond   (dec_cond)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int len_of(input int b0);
        if (b0 < 128) return 1;
        if ((b0 & 'h40) == 0 && (b0 & 'h02) != 0) return 3;
        return 2;
    endfunction

    function automatic exp_t mk(input op_t op, input int rhs, input int len,
                                input src_t src, input rel_t rel, input cond_t cond);
        exp_t e;
        e.op = op; e.rhs = 16'(rhs); e.len = 2'(len);
        e.src = src; e.rel = rel; e.cond = cond; e.loadi = 1'b0;
        return e;
    endfunction

    function automatic exp_t model_decode(input int b0, input int b1, input int b2);
        exp_t e;
        int   sel, cls, data, rhs, off;
        e    = mk(OP_ILLEGAL, 0, len_of(b0), SRC_NONE, REL_NONE, COND_NONE);
        data = (e.len == 3) ? b2 : 0;
        sel  = b0 % 8;
        cls  = b0 / 8;
        case (sel)
            0:       rhs = b1;
            1:       rhs = b1 * 256;
            2:       rhs = data;
            3:       rhs = data * 256;
            default: rhs = b1;
        endcase
        if (b0 < 128) begin
            case (b0)
                'h00: e.op = OP_NOP;
                'h01: e.op = OP_HALT;
                'h04: e.op = OP_PUSH;
                'h05: e.op = OP_POP;
                'h06: e.op = OP_RET;
                'h07: e.op = OP_NOT;
                'h08: e.op = OP_OUTLO;
                'h0A: e.op = OP_SETDP;
                'h44: begin e.op = OP_LOADI; e.src = SRC_RAM; e.rel = REL_DATA; e.loadi = 1'b1; end
                default: e.op = OP_ILLEGAL;
            endcase
        end else if (cls >= 16 && cls <= 22) begin
            e.op  = 5'(OP_LOAD + cls - 16);
            e.src = (sel < 4) ? SRC_IMM : ((sel % 2 == 0) ? SRC_RAM : SRC_IND);
            e.rel = (sel < 4) ? REL_NONE : ((sel >= 6) ? REL_STACK : REL_DATA);
        end else if (cls == 24 || cls == 26) begin
            e.op = (cls == 24) ? OP_BR : OP_CALL;
            off  = sel * 256 + b1;
            if (off >= 1024) off = off - 2048;
            rhs  = off;
        end else if (cls == 30 && sel == 0 && b1 < 4) begin
            e.op = OP_IF;
            case (b1)
                0:       e.cond = COND_Z;
                1:       e.cond = COND_NZ;
                2:       e.cond = COND_ELSE;
                default: e.cond = COND_NELSE;
            endcase
        end
        e.rhs = 16'(rhs);
        return e;
    endfunction

    function automatic logic [OBS_W-1:0] vec(input exp_t e, input logic [WORD_W-1:0] acc);
        return {1'b1, e.op, (e.loadi ? acc : e.rhs), e.len, e.src, e.rel, e.cond};
    endfunction

    function automatic logic [7:0] pick_opcode();
        case ($urandom_range(0, 9))
            0, 1, 2:    return ONE_BYTE[$urandom_range(0, 8)];
            3, 4, 5, 6: return {2'b10, 3'($urandom_range(0, 6)), 3'($urandom)};
            7:          return {5'b11110, 3'($urandom_range(0, 1))};
            8:          return {2'b11, 6'($urandom)};
            default:    return 8'($urandom);
        endcase
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pop_one;
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [OBS_W-1:0] exp_v;
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({byte_ready, w_obs} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got ready=%b obs=%h want ready=0 obs=0", byte_ready, w_obs);
        end
        @(negedge clk);
        rst = 1'b0; byte_valid = 1'b0;
        #1;
        n_cmp++;
        if ({byte_ready, w_obs} !== {1'b1, {OBS_W{1'b0}}}) begin
            n_err++;
            $display("FAIL after_reset: got ready=%b obs=%h want ready=1 obs=0", byte_ready, w_obs);
        end
        send(8'h80);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_in_reset: got %b want 0", byte_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        send(8'h01);
        #1;
        exp_v = vec(mk(OP_HALT, 0, 1, SRC_NONE, REL_NONE, COND_NONE), accum);
        n_cmp++;
        if (w_obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_mid_instr: got %h want %h", w_obs, exp_v);
        end
        pop_one;
    endtask

    task automatic test_decode;
        logic [7:0]       seq [12][3];
        int               nb  [12];
        exp_t             ex  [12];
        logic [OBS_W-1:0] exp_v;
        seq[0]  = '{8'h01, 8'h00, 8'h00}; nb[0]  = 1; ex[0]  = mk(OP_HALT, 'h0000, 1, SRC_NONE, REL_NONE, COND_NONE);
        seq[1]  = '{8'h80, 8'h34, 8'h00}; nb[1]  = 2; ex[1]  = mk(OP_LOAD, 'h0034, 2, SRC_IMM, REL_NONE, COND_NONE);
        seq[2]  = '{8'h81, 8'h12, 8'h00}; nb[2]  = 2; ex[2]  = mk(OP_LOAD, 'h1200, 2, SRC_IMM, REL_NONE, COND_NONE);
        seq[3]  = '{8'h8A, 8'h05, 8'hBE}; nb[3]  = 3; ex[3]  = mk(OP_ADD, 'h00BE, 3, SRC_IMM, REL_NONE, COND_NONE);
        seq[4]  = '{8'h8B, 8'h05, 8'hBE}; nb[4]  = 3; ex[4]  = mk(OP_ADD, 'hBE00, 3, SRC_IMM, REL_NONE, COND_NONE);
        seq[5]  = '{8'hC7, 8'hFE, 8'h00}; nb[5]  = 2; ex[5]  = mk(OP_BR, 'hFFFE, 2, SRC_NONE, REL_NONE, COND_NONE);
        seq[6]  = '{8'h02, 8'h00, 8'h00}; nb[6]  = 1; ex[6]  = mk(OP_ILLEGAL, 'h0000, 1, SRC_NONE, REL_NONE, COND_NONE);
        seq[7]  = '{8'hF0, 8'h02, 8'h00}; nb[7]  = 2; ex[7]  = mk(OP_IF, 'h0002, 2, SRC_NONE, REL_NONE, COND_ELSE);
        seq[8]  = '{8'hF1, 8'h00, 8'h00}; nb[8]  = 2; ex[8]  = mk(OP_ILLEGAL, 'h0000, 2, SRC_NONE, REL_NONE, COND_NONE);
        seq[9]  = '{8'h8F, 8'h20, 8'h33}; nb[9]  = 3; ex[9]  = mk(OP_ADD, 'h0020, 3, SRC_IND, REL_STACK, COND_NONE);
        seq[10] = '{8'h94, 8'h55, 8'h00}; nb[10] = 2; ex[10] = mk(OP_STORE, 'h0055, 2, SRC_RAM, REL_DATA, COND_NONE);
        seq[11] = '{8'hD5, 8'h03, 8'h00}; nb[11] = 2; ex[11] = mk(OP_CALL, 'hFD03, 2, SRC_NONE, REL_NONE, COND_NONE);
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < nb[i]; k++) send(seq[i][k]);
            #1;
            exp_v = vec(ex[i], accum);
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL decode_%0d: got %h want %h", i, w_obs, exp_v);
            end
            pop_one;
        end
        accum = 16'h1234;
        send(8'h44);
        #1;
        n_cmp++;
        if (w_obs !== {1'b1, 5'(OP_LOADI), 16'h1234, 2'd1, 2'(SRC_RAM), 2'(REL_DATA), 3'd0}) begin
            n_err++;
            $display("FAIL loadi_1234: got %h", w_obs);
        end
        accum = 16'h5678;
        #1;
        n_cmp++;
        if (w_obs !== {1'b1, 5'(OP_LOADI), 16'h5678, 2'd1, 2'(SRC_RAM), 2'(REL_DATA), 3'd0}) begin
            n_err++;
            $display("FAIL loadi_5678: got %h", w_obs);
        end
        pop_one;
    endtask

    task automatic test_back_pressure;
        logic [4:0] got[$];
        bit         sent;
        dec_ready = 1'b0;
        send(8'h00);
        send(8'h01);
        byte_valid = 1'b1;
        byte_data  = 8'h07;
        #1;
        n_cmp++;
        if (byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full_ready: got %b want 0", byte_ready);
        end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({byte_ready, dec_valid, dec_op} !== {1'b0, 1'b1, 5'(OP_NOP)}) begin
            n_err++;
            $display("FAIL bp_hold: got ready=%b valid=%b op=%0d want ready=0 valid=1 op=0",
                     byte_ready, dec_valid, dec_op);
        end
        dec_ready = 1'b1;
        sent      = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (dec_valid) got.push_back(dec_op);
            if (byte_valid && byte_ready) sent = 1'b1;
            @(negedge clk);
            if (sent) byte_valid = 1'b0;
            #1;
        end
        dec_ready = 1'b0;
        n_cmp++;
        if (got.size() != 3 || got[0] !== 5'(OP_NOP) || got[1] !== 5'(OP_HALT) || got[2] !== 5'(OP_NOT)) begin
            n_err++;
            $display("FAIL bp_order: got %0d entries (first ops %0d,%0d,%0d) want 3 entries 0,1,5",
                     got.size(), (got.size() > 0) ? got[0] : 5'h1f,
                     (got.size() > 1) ? got[1] : 5'h1f, (got.size() > 2) ? got[2] : 5'h1f);
        end
    endtask

    task automatic test_flush;
        logic [OBS_W-1:0] exp_v;
        send(8'h80);
        @(negedge clk);
        flush = 1'b1; byte_valid = 1'b1; byte_data = 8'h01;
        #1;
        n_cmp++;
        if (byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready: got %b want 0", byte_ready);
        end
        @(negedge clk);
        flush = 1'b0; byte_valid = 1'b0;
        #1;
        n_cmp++;
        if (w_obs !== '0) begin
            n_err++;
            $display("FAIL flush_drop: got %h want 0", w_obs);
        end
        send(8'h01);
        #1;
        exp_v = vec(mk(OP_HALT, 0, 1, SRC_NONE, REL_NONE, COND_NONE), accum);
        n_cmp++;
        if (w_obs !== exp_v) begin
            n_err++;
            $display("FAIL flush_partial: got %h want %h", w_obs, exp_v);
        end
        pop_one;
        send(8'h00);
        send(8'h01);
        @(negedge clk);
        flush = 1'b1; dec_ready = 1'b1; byte_valid = 1'b1; byte_data = 8'h04;
        @(negedge clk);
        flush = 1'b0; dec_ready = 1'b0; byte_valid = 1'b0;
        #1;
        n_cmp++;
        if (w_obs !== '0) begin
            n_err++;
            $display("FAIL flush_queue: got %h want 0", w_obs);
        end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (w_obs !== '0) begin
            n_err++;
            $display("FAIL flush_stays_empty: got %h want 0", w_obs);
        end
        send(8'h05);
        #1;
        exp_v = vec(mk(OP_POP, 0, 1, SRC_NONE, REL_NONE, COND_NONE), accum);
        n_cmp++;
        if (w_obs !== exp_v) begin
            n_err++;
            $display("FAIL flush_refill: got %h want %h", w_obs, exp_v);
        end
        pop_one;
    endtask

    task automatic test_random;
        exp_t             mq[$];
        logic [7:0]       part[$];
        logic [7:0]       stream[$];
        logic [7:0]       b0;
        logic             exp_ready;
        logic [OBS_W-1:0] exp_v;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (stream.size() == 0) begin
                b0 = pick_opcode();
                stream.push_back(b0);
                for (int k = 1; k < len_of(b0); k++)
                    stream.push_back((b0 == 8'hF0 && k == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom));
            end
            flush      = ($urandom_range(0, 99) < 3);
            byte_valid = ($urandom_range(0, 99) < 70);
            byte_data  = stream[0];
            dec_ready  = ($urandom_range(0, 99) < 60);
            accum      = WORD_W'($urandom);
            #1;
            exp_ready = !flush && (mq.size() < QDEPTH);
            n_cmp++;
            if (byte_ready !== exp_ready) begin
                n_err++;
                $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, byte_ready, exp_ready);
            end
            exp_v = (mq.size() > 0) ? vec(mq[0], accum) : '0;
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL rand_head cyc %0d: got %h want %h", cyc, w_obs, exp_v);
            end
            if (flush) begin
                mq.delete();
                part.delete();
                stream.delete();
            end else begin
                if (mq.size() > 0 && dec_ready) void'(mq.pop_front());
                if (byte_valid && exp_ready) begin
                    part.push_back(stream.pop_front());
                    if (part.size() == len_of(part[0])) begin
                        mq.push_back(model_decode(part[0], (part.size() > 1) ? part[1] : 0,
                                                  (part.size() > 2) ? part[2] : 0));
                        part.delete();
                    end
                end
            end
        end
        @(negedge clk);
        flush = 1'b0; byte_valid = 1'b0; dec_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_decode;
        test_back_pressure;
        test_flush;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
